// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary decoder.
package bcd_to_bin_seq_pkg;

  // Default geometry: two packed digits (0..99) fit in 7 result bits.
  localparam int unsigned DefDigits = 2;
  localparam int unsigned DefBinW   = 7;
  localparam int unsigned DefCntW   = 3;

  // Largest legal decimal digit.
  localparam int unsigned DigitMax  = 9;

  // Reverse double-dabble correction applied after each right shift.
  localparam int unsigned AdjThresh = 8;
  localparam int unsigned AdjValue  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle between a BCD producer and the decoder.
interface bcd_to_bin_seq_if #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start,
    output bcd_in,
    input  bin_out,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output bin_out,
    output busy,
    output done,
    output err
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction step: a digit that reached 8 or more after the
// right shift had a half-ten carried into it, so pull it back by 3.
module bcd_digit_adjust
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Subtract 3 from digits at or above the threshold; no inter-digit borrow.
  assign o_digit = (i_digit >= 4'(AdjThresh)) ? (i_digit - 4'(AdjValue)) : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary decoder (reverse double-dabble), one bit per clock.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int unsigned DIGITS = DefDigits,
  parameter int unsigned BIN_W  = DefBinW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_to_bin_seq_if.slave bus
);

  state_e                r_state;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [BIN_W-1:0]      r_bin;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_bad;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [BIN_W-1:0]      r_bin_out;

  logic [4*DIGITS-1:0]   w_bcd_shr;
  logic [4*DIGITS-1:0]   w_bcd_adj;
  logic [BIN_W-1:0]      w_bin_shr;
  logic                  w_in_bad;
  logic                  w_last;

  // BCD LSB falls into the binary MSB; the BCD word shifts right behind it.
  assign w_bcd_shr = r_bcd >> 1;
  assign w_bin_shr = {r_bcd[0], r_bin[BIN_W-1:1]};
  assign w_last    = (r_cnt == CNT_W'(BIN_W - 1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (w_bcd_shr[4*g +: 4]),
      .o_digit (w_bcd_adj[4*g +: 4])
    );
  end

  // Flag any incoming digit outside 0..9.
  always_comb begin
    w_in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'(DigitMax)) w_in_bad = 1'b1;
    end
  end

  // Control FSM with registered outputs; results are committed on the edge
  // that enters StDone so done is visible for exactly the StDone cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_bad     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_bin_out <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_bcd   <= bus.bcd_in;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_bad   <= w_in_bad;
            r_busy  <= 1'b1;
            r_state <= StShift;
          end
        end
        StShift: begin
          if (r_bad) begin
            // Invalid input: skip the shifts and report after one cycle.
            r_bin_out <= '0;
            r_err     <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= StDone;
          end else begin
            r_bcd <= w_bcd_adj;
            r_bin <= w_bin_shr;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_bin_out <= w_bin_shr;
              r_err     <= 1'b0;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= StDone;
            end
          end
        end
        StDone: begin
          // start is ignored here; a new request is taken only from StIdle.
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.bin_out = r_bin_out;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq against an arithmetic BCD model.
module tb_bcd_to_bin_seq;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned BIN_W  = 7;
  localparam int unsigned CNT_W  = 3;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  // Model of the last committed result; outputs must hold these between dones.
  logic [31:0] exp_bin_q;
  logic [31:0] exp_err_q;

  bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_val(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic ref_bad(input logic [7:0] v);
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done; reports latency in negedges after the start edge,
  // busy-high samples seen before done, and whether outputs held meanwhile.
  task automatic wait_done(output int lat, output int busy_cnt, output logic stable,
                           output logic seen);
    lat      = 0;
    busy_cnt = 0;
    stable   = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (32'(bus.bin_out) !== exp_bin_q || 32'(bus.err) !== exp_err_q) stable = 1'b0;
    end
  endtask

  task automatic conv(input logic [7:0] v);
    int   lat;
    int   bc;
    logic st;
    logic seen;
    logic e_err;
    int   e_bin;
    int   e_lat;
    e_err = ref_bad(v);
    e_bin = e_err ? 0 : ref_val(v);
    e_lat = e_err ? 2 : int'(BIN_W) + 1;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = v;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat, bc, st, seen);
    check($sformatf("done_seen_%02h", v), 32'(seen), 32'd1);
    check($sformatf("latency_%02h", v), 32'(lat), 32'(e_lat));
    check($sformatf("busy_cycles_%02h", v), 32'(bc), 32'(e_lat - 1));
    check($sformatf("hold_%02h", v), 32'(st), 32'd1);
    check($sformatf("bin_%02h", v), 32'(bus.bin_out), 32'(e_bin));
    check($sformatf("err_%02h", v), 32'(bus.err), 32'(e_err));
    check($sformatf("busy_at_done_%02h", v), 32'(bus.busy), 32'd0);
    exp_bin_q = 32'(e_bin);
    exp_err_q = 32'(e_err);
    @(negedge clk);
    check($sformatf("done_pulse_%02h", v), 32'(bus.done), 32'd0);
  endtask

  initial begin
    int   lat;
    int   bc;
    logic st;
    logic seen;
    logic quiet;
    logic [7:0] v;

    total      = 0;
    bad        = 0;
    exp_bin_q  = '0;
    exp_err_q  = '0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;

    // Reset then idle.
    repeat (2) @(negedge clk);
    check("rst_bin", 32'(bus.bin_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bin_out !== '0) quiet = 1'b0;
    end
    check("idle_quiet", 32'(quiet), 32'd1);

    // Largest value, then the named sweep points.
    conv(8'h99);
    conv(8'h00);
    conv(8'h12);
    conv(8'h50);

    // Every valid two-digit code.
    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        v = {4'(t), 4'(u)};
        conv(v);
      end
    end

    // Invalid digit followed by a valid word.
    conv(8'h4A);
    conv(8'h37);

    // Random bytes, valid and invalid alike.
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom_range(0, 255));
      conv(v);
    end

    // start held high; bcd_in changes mid-conversion and during DONE.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 8'h25;
    @(posedge clk);
    #1;
    repeat (3) @(negedge clk);
    bus.bcd_in = 8'h61;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("held_done_seen", 32'(seen), 32'd1);
    check("held_first_bin", 32'(bus.bin_out), 32'd25);
    check("held_first_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    check("held_done_ignored", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("held_next_accept", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    exp_bin_q = 32'd25;
    exp_err_q = 32'd0;
    wait_done(lat, bc, st, seen);
    check("held_second_seen", 32'(seen), 32'd1);
    check("held_second_bin", 32'(bus.bin_out), 32'd61);
    check("held_second_err", 32'(bus.err), 32'd0);
    exp_bin_q = 32'd61;

    // Reset during the shift phase aborts without a done pulse.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 8'h88;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_bin", 32'(bus.bin_out), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_err", 32'(bus.err), 32'd0);
    exp_bin_q = '0;
    exp_err_q = '0;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    check("abort_no_done", 32'(quiet), 32'd1);
    conv(8'h88);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
